// File: rtl/iter_div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per clock.
// The result and destination index are presented alongside a one-cycle done pulse.
module iter_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            sel_rem_q, sel_rem_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic            in_signed, rs1_neg, rs2_neg, div_zero, overflow;
    logic [XLEN-1:0] abs1, abs2, special_res;
    logic [XLEN:0]   shifted, trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_nx, quot_nx, final_quot, final_rem;

    // Request decode: magnitudes are taken only for signed ops.
    always_comb begin
        in_signed = ~op[0];
        rs1_neg   = in_signed & rs1[XLEN-1];
        rs2_neg   = in_signed & rs2[XLEN-1];
        abs1      = rs1_neg ? -rs1 : rs1;
        abs2      = rs2_neg ? -rs2 : rs2;
        div_zero  = (rs2 == '0);
        overflow  = in_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        if (div_zero)
            special_res = op[1] ? rs1 : '1;
        else
            special_res = op[1] ? '0 : rs1;
    end

    // One restoring step; the trial subtract is one bit wider so its MSB is the borrow.
    always_comb begin
        shifted    = {rem_q, quot_q[XLEN-1]};
        trial      = shifted - {1'b0, divisor_q};
        trial_ok   = ~trial[XLEN];
        rem_nx     = trial_ok ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quot_nx    = {quot_q[XLEN-2:0], trial_ok};
        final_quot = neg_quot_q ? -quot_nx : quot_nx;
        final_rem  = neg_rem_q ? -rem_nx : rem_nx;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        sel_rem_d  = sel_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        rd_d       = rd_q;
        result_d   = result_q;
        rd_out_d   = rd_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_rem_d  = op[1];
                    rd_d       = rd_in;
                    quot_d     = abs1;
                    divisor_d  = abs2;
                    neg_quot_d = rs1_neg ^ rs2_neg;
                    neg_rem_d  = rs1_neg;
                    rem_d      = '0;
                    count_d    = '0;
                    if (div_zero || overflow) begin
                        result_d = special_res;
                        rd_out_d = rd_in;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d   = rem_nx;
                quot_d  = quot_nx;
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    result_d = sel_rem_q ? final_rem : final_quot;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            sel_rem_q  <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            sel_rem_q  <= sel_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed-vector bench for iter_div_unit: signed/unsigned results, special cases,
// latency, start-while-busy and mid-calculation reset.
module tb_iter_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    iter_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    // Issues one request and waits (bounded) for done; reports what was seen, no checking.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output logic one_shot);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1 = 32'hDEAD_BEEF; rs2 = 32'h0000_0003; op = ~o; rd_in = ~rd;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        rdo = rd_out;
        @(posedge clk);
        #1;
        one_shot = !done && !busy;
        $display("op=%0d rs1=%08h rs2=%08h rd=%0d -> result=%08h rd_out=%0d latency=%0d",
                 o, a, b, rd, res, rdo, lat);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, result, rd_out} !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b result=%08h rd_out=%0d, need all 0",
                     busy, done, result, rd_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] res; logic [4:0] rdo; int lat; logic os;
        run_op(OP_DIV, 32'd100, 32'd7, 5'd5, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'd14) begin n_bad++; $display("FAIL div_100_7: got %08h need %08h", res, 32'd14); end
        n_cmp++;
        if (rdo !== 5'd5) begin n_bad++; $display("FAIL div_rd_out: got %0d need 5", rdo); end
        n_cmp++;
        if (lat !== 32) begin n_bad++; $display("FAIL div_latency: got %0d need 32", lat); end
        n_cmp++;
        if (os !== 1'b1) begin n_bad++; $display("FAIL div_done_pulse: got %b need 1", os); end
        run_op(OP_REM, 32'd100, 32'd7, 5'd6, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'd2) begin n_bad++; $display("FAIL rem_100_7: got %08h need %08h", res, 32'd2); end
    endtask

    task automatic test_signed();
        logic [31:0] res; logic [4:0] rdo; int lat; logic os;
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd1, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL div_m100_7: got %08h need FFFFFFF2", res); end
        run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd2, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL rem_m100_7: got %08h need FFFFFFFE", res); end
        run_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd3, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'd2) begin n_bad++; $display("FAIL rem_100_m7: got %08h need 00000002", res); end
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd4, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL div_100_m7: got %08h need FFFFFFF2", res); end
        run_op(OP_DIV, 32'h8000_0000, 32'd1, 5'd7, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL div_min_1: got %08h need 80000000", res); end
    endtask

    task automatic test_unsigned();
        logic [31:0] res; logic [4:0] rdo; int lat; logic os;
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 5'd8, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL divu_max_2: got %08h need 7FFFFFFF", res); end
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'd2, 5'd9, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'd1) begin n_bad++; $display("FAIL remu_max_2: got %08h need 00000001", res); end
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'd0) begin n_bad++; $display("FAIL divu_min_m1: got %08h need 00000000", res); end
        run_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL remu_min_m1: got %08h need 80000000", res); end
    endtask

    task automatic test_special();
        logic [31:0] res; logic [4:0] rdo; int lat; logic os;
        run_op(OP_DIVU, 32'd5, 32'd0, 5'd12, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divu_by_zero: got %08h need FFFFFFFF", res); end
        n_cmp++;
        if (lat !== 0) begin n_bad++; $display("FAIL special_latency: got %0d edges after start need 0", lat); end
        n_cmp++;
        if (rdo !== 5'd12) begin n_bad++; $display("FAIL special_rd_out: got %0d need 12", rdo); end
        n_cmp++;
        if (os !== 1'b1) begin n_bad++; $display("FAIL special_done_pulse: got %b need 1", os); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd13, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_by_zero: got %08h need FFFFFFFF", res); end
        run_op(OP_REM, 32'd5, 32'd0, 5'd14, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'd5) begin n_bad++; $display("FAIL rem_by_zero: got %08h need 00000005", res); end
        run_op(OP_REMU, 32'hFFFF_FFF9, 32'd0, 5'd15, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL remu_by_zero: got %08h need FFFFFFF9", res); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL div_overflow: got %08h need 80000000", res); end
        n_cmp++;
        if (lat !== 0) begin n_bad++; $display("FAIL overflow_latency: got %0d need 0", lat); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'd0) begin n_bad++; $display("FAIL rem_overflow: got %08h need 00000000", res); end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        int first_done = -1;
        logic [31:0] res = '0;
        logic [4:0] rdo = '0;
        @(negedge clk);
        op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 3 || c == 10) begin
                op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (first_done < 0) begin first_done = c; res = result; rdo = rd_out; end
            end
        end
        start = 1'b0;
        $display("busy-start: dones=%0d first_done_edge=%0d result=%08h rd_out=%0d",
                 dones, first_done, res, rdo);
        n_cmp++;
        if (dones !== 1) begin n_bad++; $display("FAIL busy_single_done: got %0d dones need 1", dones); end
        n_cmp++;
        if (first_done !== 32) begin n_bad++; $display("FAIL busy_latency: got %0d need 32", first_done); end
        n_cmp++;
        if (res !== 32'd14) begin n_bad++; $display("FAIL busy_result: got %08h need 0000000E", res); end
        n_cmp++;
        if (rdo !== 5'd5) begin n_bad++; $display("FAIL busy_rd_out: got %0d need 5", rdo); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] res; logic [4:0] rdo; int lat; logic os;
        int dones = 0;
        @(negedge clk);
        op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        $display("mid-reset: busy=%b done=%b result=%08h rd_out=%0d", busy, done, result, rd_out);
        n_cmp++;
        if ({busy, done, result, rd_out} !== 39'd0) begin
            n_bad++;
            $display("FAIL mid_reset_state: busy=%b done=%b result=%08h rd_out=%0d, need all 0",
                     busy, done, result, rd_out);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin n_bad++; $display("FAIL mid_reset_abort: got %0d active cycles need 0", dones); end
        run_op(OP_DIVU, 32'd1000, 32'd3, 5'd21, res, rdo, lat, os);
        n_cmp++;
        if (res !== 32'd333 || rdo !== 5'd21 || lat !== 32) begin
            n_bad++;
            $display("FAIL after_reset_op: got result=%08h rd=%0d lat=%0d need 0000014D 21 32", res, rdo, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_unsigned();
        test_special();
        test_start_while_busy();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
